// File: rtl/xbar_pkg.sv
// Shared constants for the round-robin crossbar slave: FSM encoding and command codes.
package xbar_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam int WAIT_CNT_W = 4;

  typedef logic [1:0] state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after last_grant, wrapping.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             enable,
  output logic [N-1:0]     grant
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    if (enable) begin
      for (int k = N; k >= 1; k--) begin
        idx = IDX_W'((int'(last_grant) + k) % N);
        if (req[idx]) begin
          grant      = '0;
          grant[idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/xbar_slave_rr.sv
// Single-ported storage slave shared by N_MASTERS masters through a round-robin arbiter;
// one transaction at a time: IDLE -> ACCESS (WAIT_STATES+1 cycles) -> ACK -> DONE.
module xbar_slave_rr
  import xbar_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int N_MASTERS   = 2,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N_MASTERS-1:0]             req,
  input  logic [N_MASTERS-1:0]             cmd,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]  addr,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]  wdata,
  output logic [N_MASTERS-1:0]             ack,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [N_MASTERS-1:0]             grant,
  output logic                             busy
);

  localparam int IDX_W  = $clog2(N_MASTERS);
  localparam int AIDX_W = $clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);
  localparam logic [IDX_W-1:0]      LAST_INIT = IDX_W'(N_MASTERS - 1);

  state_t                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [N_MASTERS-1:0]    win_q, win_d;
  logic                    cmd_q, cmd_d;
  logic [AIDX_W-1:0]       addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    mem_we;
  logic [DEPTH-1:0]        word_we;

  logic [N_MASTERS-1:0]    arb_grant;
  logic [IDX_W-1:0]        win_idx;
  logic                    sel_cmd;
  logic [AIDX_W-1:0]       sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  // Address bits above the word index alias by design; decode happens upstream.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr;

  rr_arbiter #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (req),
    .last_grant (last_q),
    .enable     (state_q == ST_IDLE),
    .grant      (arb_grant)
  );

  always_comb begin
    win_idx   = '0;
    sel_cmd   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (arb_grant[i]) begin
        win_idx   = IDX_W'(i);
        sel_cmd   = cmd[i];
        sel_addr  = addr[i*ADDR_WIDTH +: AIDX_W];
        sel_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    win_d   = win_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_ACCESS;
          cnt_d   = WAIT_INIT;
          last_d  = win_idx;
          win_d   = arb_grant;
          cmd_d   = sel_cmd;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_ACK;
          if (cmd_q == CMD_WRITE) begin
            mem_we  = 1'b1;
            rdata_d = '0;
          end else begin
            rdata_d = mem_q[addr_q];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_DONE;
        rdata_d = '0;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= LAST_INIT;
      win_q   <= '0;
      cmd_q   <= CMD_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      win_q   <= win_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word_we
      assign word_we[gi] = mem_we && (addr_q == AIDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (word_we[i]) mem_q[i] <= wdata_q;
      end
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign grant = (state_q == ST_ACCESS || state_q == ST_ACK) ? win_q : '0;
  assign ack   = (state_q == ST_ACK) ? win_q : '0;
  assign rdata = rdata_q;

endmodule

// File: doc/xbar_slave_rr.md
XBAR_SLAVE_RR -- requirements
Module: xbar_slave_rr

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 32, data word width.
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 16, master address width.
REQ-003 The block SHALL expose parameter N_MASTERS, default 2, number of master ports (legal 2..8).
REQ-004 The block SHALL expose parameter DEPTH, default 16, storage words (power of two, 2..256).
REQ-005 The block SHALL expose parameter WAIT_STATES, default 0, extra access cycles before ack (0..15).
REQ-006 The block SHALL use one clock and an asynchronous active-low reset, with ports named clock and reset.
REQ-007 clock  input  1  sole clock; all state updates on its rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 req  input  N_MASTERS  per-master transaction request; bit i belongs to master i.
REQ-010 cmd  input  N_MASTERS  per-master operation: 0 read, 1 write.
REQ-011 addr  input  N_MASTERS*ADDR_WIDTH  per-master address; slice i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 wdata  input  N_MASTERS*DATA_WIDTH  per-master write data; slice i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 ack  output  N_MASTERS  one-cycle completion pulse to the granted master.
REQ-014 rdata  output  DATA_WIDTH  read data, valid only while the corresponding ack bit is high.
REQ-015 grant  output  N_MASTERS  one-hot owner of the slave; all zero when not serving.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, ACCESS, ACK, DONE.
REQ-018 IDLE -> ACCESS when any req bit is 1; winner latched by round-robin; cmd, addr, wdata latched from the winner on the same edge.
REQ-019 Round-robin search SHALL start at (last_grant+1) mod N_MASTERS and wrap; last_grant updates on each IDLE -> ACCESS.
REQ-020 ACCESS SHALL last WAIT_STATES+1 cycles, counted by a down-counter loaded at entry; ACCESS -> ACK when counter is 0.
REQ-021 On the ACCESS -> ACK edge a write SHALL store latched wdata at mem[addr[log2(DEPTH)-1:0]]; a read SHALL register that word into rdata.
REQ-022 Upper address bits above log2(DEPTH) SHALL be ignored (aliasing by design; slave decode is done upstream).
REQ-023 ACK SHALL last exactly one cycle with ack[winner]=1; ACK -> DONE unconditionally.
REQ-024 DONE SHALL last one cycle, ignore all req, and return to IDLE; this is the master's req-drop window.
REQ-025 Latency with WAIT_STATES=0: req sampled at edge k, ack high in cycle after edge k+1, IDLE again after edge k+3.
REQ-026 grant SHALL equal the one-hot winner in ACCESS and ACK, zero in IDLE and DONE.
REQ-027 rdata SHALL be zero whenever no ack bit is high, and after a write ack.
REQ-028 A winner dropping req during ACCESS SHALL NOT abort the transaction; it completes and acks.
REQ-029 Simultaneous requests SHALL be served one per transaction in round-robin order; no master is starved beyond N_MASTERS-1 transactions.
REQ-030 A master still holding req in IDLE after DONE SHALL be re-arbitrated like any other requester.

Reset
REQ-031 While reset=0: state IDLE, ack 0, rdata 0, grant 0, busy 0, counter 0, last_grant N_MASTERS-1 (master 0 wins first).
REQ-032 All DEPTH storage words SHALL be cleared to 0 by reset.
REQ-033 Reset asserted mid-transaction SHALL abort it immediately; an in-flight write not yet at the ACCESS -> ACK edge SHALL NOT land.

Structure
REQ-034 Package xbar_pkg SHALL hold the state encoding and CMD_READ=0 / CMD_WRITE=1 constants.
REQ-035 Arbitration SHALL be a sub-module rr_arbiter (inputs req, last_grant, enable; output one-hot grant).
REQ-036 Storage SHALL be a plain register array inside xbar_slave_rr; no vendor RAM macros.

Verification
REQ-037 Master 0 write addr 16'h0001 data 32'h12345678, then read 16'h0001 -> ack[0] pulses once each; read rdata=32'h12345678.
REQ-038 Masters 0 and 1 write simultaneously (16'h0003/32'hEDB3, 16'h0004/32'hCEA3) from reset -> master 0 acked first, master 1 second; readback returns both values.
REQ-039 N_MASTERS=4, all four hold req continuously -> ack order 0,1,2,3,0; grant one-hot throughout ACCESS/ACK.
REQ-040 WAIT_STATES=3 read -> ack appears exactly 3 cycles later than WAIT_STATES=0; busy high from ACCESS through DONE.
REQ-041 Write 16'h0010 with DEPTH=16 -> lands at word 0; read 16'h0000 returns it.
REQ-042 Assert reset during ACCESS of write 32'hDEAD to 16'h0002 -> no ack, outputs at reset values, subsequent read of 16'h0002 returns 0.
